mcr3_rom_dl_sched: RTL and testbench

- Sequences the serial ROM download stream into the three memory destinations of the MCR3 monoboard core: SDRAM port1 (main CPU and Sounds Good ROMs), SDRAM port2 (sprite ROMs), and on-chip GFX1 BRAM.
- Routes each byte by address region and applies region-specific address swizzles.
- Runs the toggle req/ack handshake with the SDRAM controller and returns a one-cycle ack to the loader.
- After download completes, owns the rom_loaded flag and the stretched core reset.

---
 rtl/mcr3_rom_dl_sched.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mcr3_rom_dl_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcr3_rom_dl_sched.sv
// MCR3 ROM download scheduler.
// Takes the serial ioctl byte stream and steers each byte to SDRAM port1
// (main CPU and sound ROMs), SDRAM port2 (sprite ROMs) or the GFX1 BRAM.
// Region-specific address swizzles are applied on the way through.
// The block also owns the rom_loaded flag and the stretched core reset
// that follows the end of a download.
module mcr3_rom_dl_sched #(
    parameter logic [19:0] SP_OFFSET   = 20'h10000,
    parameter logic [19:0] GFX1_OFFSET = 20'h50000,
    parameter logic [19:0] SND_OFFSET  = 20'h58000,
    parameter bit          SP_WIDE     = 1'b1,
    parameter logic [15:0] RESET_HOLD  = 16'hFFFF,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_ack,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [23:0] port1_a,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [23:0] port2_a,
    output logic [7:0]  mem_d,
    output logic [15:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT1 = 3'd2;
    localparam logic [2:0] ST_WAIT2 = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] RG_MAIN = 2'd0;
    localparam logic [1:0] RG_SPR  = 2'd1;
    localparam logic [1:0] RG_GFX  = 2'd2;
    localparam logic [1:0] RG_SND  = 2'd3;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic        wr_q;
    logic        downl_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]  region_q;
    logic [7:0]  mem_d_q;
    logic [23:0] port1_a_q;
    logic [23:0] port2_a_q;
    logic [15:0] dl_addr_q;
    logic [7:0]  dl_data_q;
    logic        port1_req_q;
    logic        port2_req_q;
    logic        ack_q;
    logic        rom_loaded_q;
    logic [15:0] hold_q;
    logic        err_tmo_q;
    logic        err_ovr_q;

    logic        wr_edge;
    logic        downl_rise;
    logic        downl_fall;
    logic [1:0]  in_region;
    logic [17:0] snd_s;
    logic [23:0] snd_addr;
    logic [23:0] spr_p;
    logic [23:0] spr_addr;
    logic [15:0] gfx_addr;
    logic        accept;
    logic        tog1;
    logic        tog2;
    logic        tmo_hit;
    logic        done_hit;
    logic        overrun;

    // Byte strobes only count while a download is in progress.
    assign wr_edge    = ioctl_wr & ~wr_q & ioctl_downl;
    assign downl_rise = ioctl_downl & ~downl_q;
    assign downl_fall = ~ioctl_downl & downl_q;
    assign overrun    = wr_edge && (state_q != ST_IDLE);

    // Classify the incoming byte address and precompute every swizzled form;
    // only the one matching the region is latched on acceptance.
    always_comb begin
        in_region = RG_SND;
        if (ioctl_addr < {5'd0, SP_OFFSET}) begin
            in_region = RG_MAIN;
        end else if (ioctl_addr < {5'd0, GFX1_OFFSET}) begin
            in_region = RG_SPR;
        end else if (ioctl_addr < {5'd0, SND_OFFSET}) begin
            in_region = RG_GFX;
        end
        snd_s    = ioctl_addr[17:0] - SND_OFFSET[17:0];
        snd_addr = {4'd0, SND_OFFSET} + {6'd0, snd_s[17], snd_s[15:0], snd_s[16]};
        spr_p    = ioctl_addr[23:0] - {4'd0, SP_OFFSET};
        spr_addr = SP_WIDE ? {spr_p[23:18], spr_p[15:0], spr_p[17:16]}
                           : {spr_p[23:17], spr_p[14:0], spr_p[16:15]};
        gfx_addr = ioctl_addr[15:0] - GFX1_OFFSET[15:0];
    end

    // Next-state logic: one byte in flight, one outstanding port request,
    // and a bounded wait for the SDRAM ack.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        accept     = 1'b0;
        tog1       = 1'b0;
        tog2       = 1'b0;
        tmo_hit    = 1'b0;
        done_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_edge) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = 16'd0;
                if (region_q == RG_GFX) begin
                    state_d = ST_DONE;
                end else if (region_q == RG_SPR) begin
                    tog2    = 1'b1;
                    state_d = ST_WAIT2;
                end else begin
                    tog1    = 1'b1;
                    state_d = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (port1_req_q == port1_ack) begin
                    state_d = ST_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_WAIT2: begin
                if (port2_req_q == port2_ack) begin
                    state_d = ST_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                done_hit = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Input history for edge detection plus the FSM registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_q       <= 1'b0;
            downl_q    <= 1'b0;
            state_q    <= ST_IDLE;
            wait_cnt_q <= 16'd0;
        end else begin
            wr_q       <= ioctl_wr;
            downl_q    <= ioctl_downl;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Latch the accepted byte and its destination address in one go.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            region_q  <= RG_MAIN;
            mem_d_q   <= 8'd0;
            port1_a_q <= 24'd0;
            port2_a_q <= 24'd0;
            dl_addr_q <= 16'd0;
            dl_data_q <= 8'd0;
        end else if (accept) begin
            region_q <= in_region;
            mem_d_q  <= ioctl_dout;
            case (in_region)
                RG_MAIN: port1_a_q <= ioctl_addr[23:0];
                RG_SND:  port1_a_q <= snd_addr;
                RG_SPR:  port2_a_q <= spr_addr;
                default: begin
                    dl_addr_q <= gfx_addr;
                    dl_data_q <= ioctl_dout;
                end
            endcase
        end
    end

    // Toggle-style requests; a timed-out request is left as is.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            port1_req_q <= 1'b0;
            port2_req_q <= 1'b0;
        end else begin
            if (tog1) begin
                port1_req_q <= ~port1_req_q;
            end
            if (tog2) begin
                port2_req_q <= ~port2_req_q;
            end
        end
    end

    // Loader ack pulse and sticky error flags, cleared when a new download starts.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ack_q     <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            ack_q <= done_hit;
            if (downl_rise) begin
                err_tmo_q <= 1'b0;
                err_ovr_q <= 1'b0;
            end
            if (tmo_hit) begin
                err_tmo_q <= 1'b1;
            end
            if (overrun) begin
                err_ovr_q <= 1'b1;
            end
        end
    end

    // Download completion tracking and the post-load reset stretch.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_loaded_q <= 1'b0;
            hold_q       <= 16'd0;
        end else if (downl_fall) begin
            rom_loaded_q <= 1'b1;
            hold_q       <= RESET_HOLD;
        end else begin
            if (downl_rise) begin
                rom_loaded_q <= 1'b0;
            end
            if (hold_q != 16'd0) begin
                hold_q <= hold_q - 16'd1;
            end
        end
    end

    assign ioctl_ack   = ack_q;
    assign port1_req   = port1_req_q;
    assign port2_req   = port2_req_q;
    assign port1_a     = port1_a_q;
    assign port2_a     = port2_a_q;
    assign mem_d       = mem_d_q;
    assign dl_addr     = dl_addr_q;
    assign dl_data     = dl_data_q;
    assign dl_wr       = (state_q == ST_ISSUE) && (region_q == RG_GFX);
    assign rom_loaded  = rom_loaded_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;
    assign core_reset  = reset | ioctl_downl | ~rom_loaded_q | (hold_q != 16'd0);

endmodule

// File: tb/tb_mcr3_rom_dl_sched.sv
// Self-checking bench for mcr3_rom_dl_sched.
// Two instances share the stimulus: one with wide sprite interleave and one
// with narrow, so both sprite swizzles are exercised by the same bytes.
module tb_mcr3_rom_dl_sched;

    localparam int          T_OUT = 255;
    localparam logic [15:0] HOLD  = 16'd16;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_downl;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        port1_ack;
    logic        port2_ack;

    logic        w_ioctl_ack, w_port1_req, w_port2_req, w_dl_wr;
    logic [23:0] w_port1_a, w_port2_a;
    logic [7:0]  w_mem_d, w_dl_data;
    logic [15:0] w_dl_addr;
    logic        w_rom_loaded, w_core_reset, w_err_timeout, w_err_overrun;

    logic        n_ioctl_ack, n_port1_req, n_port2_req, n_dl_wr;
    logic [23:0] n_port1_a, n_port2_a;
    logic [7:0]  n_mem_d, n_dl_data;
    logic [15:0] n_dl_addr;
    logic        n_rom_loaded, n_core_reset, n_err_timeout, n_err_overrun;

    int assertCount = 0;
    int failCount   = 0;

    // Reference state kept by the bench.
    logic expP1     = 1'b0;
    logic expP2     = 1'b0;
    logic expErrTmo = 1'b0;
    logic expErrOvr = 1'b0;

    always #5 clk_sys = ~clk_sys;

    mcr3_rom_dl_sched #(
        .SP_WIDE    (1'b1),
        .RESET_HOLD (HOLD),
        .TIMEOUT    (T_OUT)
    ) dutWide (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_ack   (w_ioctl_ack),
        .port1_req   (w_port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (w_port1_a),
        .port2_req   (w_port2_req),
        .port2_ack   (port2_ack),
        .port2_a     (w_port2_a),
        .mem_d       (w_mem_d),
        .dl_addr     (w_dl_addr),
        .dl_data     (w_dl_data),
        .dl_wr       (w_dl_wr),
        .rom_loaded  (w_rom_loaded),
        .core_reset  (w_core_reset),
        .err_timeout (w_err_timeout),
        .err_overrun (w_err_overrun)
    );

    mcr3_rom_dl_sched #(
        .SP_WIDE    (1'b0),
        .RESET_HOLD (HOLD),
        .TIMEOUT    (T_OUT)
    ) dutNarrow (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_ack   (n_ioctl_ack),
        .port1_req   (n_port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (n_port1_a),
        .port2_req   (n_port2_req),
        .port2_ack   (port2_ack),
        .port2_a     (n_port2_a),
        .mem_d       (n_mem_d),
        .dl_addr     (n_dl_addr),
        .dl_data     (n_dl_data),
        .dl_wr       (n_dl_wr),
        .rom_loaded  (n_rom_loaded),
        .core_reset  (n_core_reset),
        .err_timeout (n_err_timeout),
        .err_overrun (n_err_overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // 0 = main CPU, 1 = sprite, 2 = gfx1, 3 = sound
    function automatic int regionOf(input logic [24:0] a);
        longint unsigned av = longint'(a);
        if (av < 64'h10000) return 0;
        if (av < 64'h50000) return 1;
        if (av < 64'h58000) return 2;
        return 3;
    endfunction

    function automatic logic [23:0] port1Model(input logic [24:0] a);
        longint unsigned av = longint'(a);
        longint unsigned s;
        if (regionOf(a) == 0) return 24'(av);
        s = av - 64'h58000;
        return 24'(64'h58000 + (((s >> 17) & 1) << 17) + ((s & 64'hFFFF) << 1) + ((s >> 16) & 1));
    endfunction

    function automatic logic [23:0] port2Model(input logic [24:0] a, input bit wide);
        longint unsigned p = longint'(a) - 64'h10000;
        if (wide)
            return 24'((((p >> 18) & 64'h3F) << 18) + ((p & 64'hFFFF) << 2) + ((p >> 16) & 3));
        return 24'((((p >> 17) & 64'h7F) << 17) + ((p & 64'h7FFF) << 2) + ((p >> 15) & 3));
    endfunction

    // One complete byte transfer: strobe, SDRAM responder, observation, checks.
    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data,
                                 input int delay, input bit ackOn, input bit overrunAt);
        int   reg_   = regionOf(addr);
        int   ackCnt = 0;
        int   ackAt  = -1;
        int   dlCnt  = 0;
        int   dlAt   = -1;
        int   t1     = 0;
        int   t2     = 0;
        int   waited = 0;
        int   expLat;
        logic [15:0] dlA = 16'd0;
        logic [7:0]  dlD = 8'd0;
        logic p1Prev = w_port1_req;
        logic p2Prev = w_port2_req;

        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        for (int k = 1; k <= T_OUT + 30; k++) begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            if (overrunAt && k == 10) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'h00777;
                ioctl_dout = ~data;
            end
            if (w_ioctl_ack) begin
                ackCnt++;
                if (ackAt < 0) ackAt = k;
            end
            if (w_dl_wr) begin
                dlCnt++;
                dlAt = k;
                dlA  = w_dl_addr;
                dlD  = w_dl_data;
            end
            if (w_port1_req != p1Prev) begin
                t1++;
                p1Prev = w_port1_req;
            end
            if (w_port2_req != p2Prev) begin
                t2++;
                p2Prev = w_port2_req;
            end
            if (ackOn && (w_port1_req != port1_ack || w_port2_req != port2_ack)) begin
                if (waited == delay) begin
                    port1_ack = w_port1_req;
                    port2_ack = w_port2_req;
                    waited    = 0;
                end else begin
                    waited++;
                end
            end
            if (ackAt > 0 && k >= ackAt + 2) break;
        end

        if (reg_ == 2)      expLat = 3;
        else if (ackOn)     expLat = 4 + delay;
        else                expLat = T_OUT + 3;
        if (reg_ == 0 || reg_ == 3) expP1 = ~expP1;
        if (reg_ == 1)              expP2 = ~expP2;
        if (!ackOn && reg_ != 2) expErrTmo = 1'b1;
        if (overrunAt)           expErrOvr = 1'b1;

        checkOutput("ackCount", ackCnt, 1);
        checkOutput("ackLatency", ackAt, expLat);
        checkOutput("port1Toggles", t1, (reg_ == 0 || reg_ == 3) ? 1 : 0);
        checkOutput("port2Toggles", t2, (reg_ == 1) ? 1 : 0);
        checkOutput("port1Req", {31'd0, w_port1_req}, {31'd0, expP1});
        checkOutput("port2Req", {31'd0, w_port2_req}, {31'd0, expP2});
        checkOutput("memD", {24'd0, w_mem_d}, {24'd0, data});
        checkOutput("errTimeout", {31'd0, w_err_timeout}, {31'd0, expErrTmo});
        checkOutput("errOverrun", {31'd0, w_err_overrun}, {31'd0, expErrOvr});
        if (reg_ == 0 || reg_ == 3) begin
            checkOutput("port1A", {8'd0, w_port1_a}, {8'd0, port1Model(addr)});
        end else if (reg_ == 1) begin
            checkOutput("port2AWide", {8'd0, w_port2_a}, {8'd0, port2Model(addr, 1'b1)});
            checkOutput("port2ANarrow", {8'd0, n_port2_a}, {8'd0, port2Model(addr, 1'b0)});
        end else begin
            checkOutput("dlWrCount", dlCnt, 1);
            checkOutput("dlWrCycle", dlAt, 1);
            checkOutput("dlAddr", {16'd0, dlA}, 32'(longint'(addr) - 64'h50000));
            checkOutput("dlData", {24'd0, dlD}, {24'd0, data});
        end
        if (reg_ != 2) checkOutput("noDlWr", dlCnt, 0);

        // a timed-out request is acknowledged late so the next byte starts clean
        if (!ackOn) begin
            @(negedge clk_sys);
            port1_ack = w_port1_req;
            port2_ack = w_port2_req;
            @(negedge clk_sys);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        logic [24:0] a;
        logic [7:0]  heldData;

        reset       = 1'b1;
        ioctl_downl = 1'b0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = 25'd0;
        ioctl_dout  = 8'd0;
        port1_ack   = 1'b0;
        port2_ack   = 1'b0;
        repeat (3) @(negedge clk_sys);

        $display("[TB] reset state");
        checkOutput("rstCoreReset", {31'd0, w_core_reset}, 32'd1);
        checkOutput("rstOutputs", {w_ioctl_ack, w_dl_wr, w_port1_req, w_port2_req,
                                   w_rom_loaded, w_err_timeout, w_err_overrun},
                    32'd0);
        checkOutput("rstAddrData", {8'd0, w_port1_a | w_port2_a | {8'd0, w_dl_addr} | {16'd0, w_mem_d, w_dl_data}},
                    32'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        checkOutput("postRstCoreReset", {31'd0, w_core_reset}, 32'd1);
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);

        $display("[TB] directed transfers");
        applyStimulus(25'h01234, 8'hA5, 1, 1'b1, 1'b0);
        checkOutput("mainAddrConst", {8'd0, w_port1_a}, 32'h001234);
        applyStimulus(25'h68001, 8'h11, 0, 1'b1, 1'b0);
        checkOutput("sndSwzConst", {8'd0, w_port1_a}, 32'h058003);
        applyStimulus(25'h78000, 8'h22, 2, 1'b1, 1'b0);
        checkOutput("sndHighConst", {8'd0, w_port1_a}, 32'h078000);
        applyStimulus(25'h40005, 8'h33, 1, 1'b1, 1'b0);
        checkOutput("sprWideConst", {8'd0, w_port2_a}, 32'h000017);
        applyStimulus(25'h28005, 8'h44, 0, 1'b1, 1'b0);
        checkOutput("sprNarrowConst", {8'd0, n_port2_a}, 32'h000017);
        applyStimulus(25'h50010, 8'h3C, 0, 1'b1, 1'b0);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 25'($urandom_range(0, 32'hFFFF));
                1:       a = 25'(32'h10000 + $urandom_range(0, 32'h3FFFF));
                2:       a = 25'(32'h50000 + $urandom_range(0, 32'h7FFF));
                default: a = 25'(32'h58000 + $urandom_range(0, 32'h3FFFF));
            endcase
            applyStimulus(a, 8'($urandom), int'($urandom_range(0, 5)), 1'b1, 1'b0);
        end

        $display("[TB] timeout with overrun");
        applyStimulus(25'h00100, 8'h5A, 0, 1'b0, 1'b1);
        applyStimulus(25'h00200, 8'h6B, 1, 1'b1, 1'b0);

        $display("[TB] download end and reset stretch");
        ioctl_downl = 1'b0;
        cnt = 0;
        while (!w_rom_loaded && cnt < 10) begin
            @(negedge clk_sys);
            cnt++;
        end
        checkOutput("romLoaded", {31'd0, w_rom_loaded}, 32'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!w_core_reset) break;
            cnt++;
            @(negedge clk_sys);
        end
        checkOutput("holdCycles", cnt, {16'd0, HOLD});
        checkOutput("coreResetReleased", {31'd0, w_core_reset}, 32'd0);

        heldData   = w_mem_d;
        ioctl_addr = 25'h00300;
        ioctl_dout = ~heldData;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (w_ioctl_ack) cnt++;
            @(negedge clk_sys);
        end
        checkOutput("noAckOutsideDownload", cnt, 0);
        checkOutput("memDUnchanged", {24'd0, w_mem_d}, {24'd0, heldData});

        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        expErrTmo = 1'b0;
        expErrOvr = 1'b0;
        checkOutput("reloadRomLoaded", {31'd0, w_rom_loaded}, 32'd0);
        checkOutput("reloadErrClear", {30'd0, w_err_timeout, w_err_overrun}, 32'd0);
        checkOutput("reloadCoreReset", {31'd0, w_core_reset}, 32'd1);

        ioctl_downl = 1'b0;
        repeat (6) @(negedge clk_sys);
        checkOutput("midHoldRomLoaded", {31'd0, w_rom_loaded}, 32'd1);
        checkOutput("midHoldCoreReset", {31'd0, w_core_reset}, 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        checkOutput("resetRomLoaded", {31'd0, w_rom_loaded}, 32'd0);
        checkOutput("resetCoreReset", {31'd0, w_core_reset}, 32'd1);
        checkOutput("resetReqs", {30'd0, w_port1_req, w_port2_req}, 32'd0);
        reset = 1'b0;
        repeat (HOLD + 4) @(negedge clk_sys);
        checkOutput("afterResetCoreReset", {31'd0, w_core_reset}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
